// File: rtl/avmm_host_page_boundary_splitter.sv
// Splits AVMM read/write bursts so no sub-burst crosses a BOUNDARY_WORDS-aligned host page.
// Zero added latency: sink command outputs are combinational from source inputs plus state.
// Backpressure: src_waitrequest follows snk_waitrequest, and is forced high on non-final read pieces.
// Optional HOST_PAGE_SPLIT_STATS_EN adds split_count (extra sub-bursts, saturating) and split_busy.
module avmm_host_page_boundary_splitter #(
  parameter int ADDR_WIDTH       = 48,
  parameter int DATA_WIDTH       = 512,
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int BOUNDARY_WORDS   = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_WIDTH-1:0]       src_address,
  input  logic [BURSTCOUNT_WIDTH-1:0] src_burstcount,
  input  logic                        src_read,
  input  logic                        src_write,
  input  logic [DATA_WIDTH-1:0]       src_writedata,
  input  logic [DATA_WIDTH/8-1:0]     src_byteenable,
  output logic                        src_waitrequest,
  output logic [DATA_WIDTH-1:0]       src_readdata,
  output logic                        src_readdatavalid,
  output logic [ADDR_WIDTH-1:0]       snk_address,
  output logic [BURSTCOUNT_WIDTH-1:0] snk_burstcount,
  output logic                        snk_read,
  output logic                        snk_write,
  output logic [DATA_WIDTH-1:0]       snk_writedata,
  output logic [DATA_WIDTH/8-1:0]     snk_byteenable,
  input  logic                        snk_waitrequest,
  input  logic [DATA_WIDTH-1:0]       snk_readdata,
  input  logic                        snk_readdatavalid
`ifdef HOST_PAGE_SPLIT_STATS_EN
  ,
  output logic [31:0]                 split_count,
  output logic                        split_busy
`endif
);

  // Page offset bits, and an arithmetic width wide enough to hold a full page (room == BOUNDARY_WORDS).
  localparam int OW = $clog2(BOUNDARY_WORDS);
  localparam int CW = (OW + 1 > BURSTCOUNT_WIDTH + 1) ? OW + 1 : BURSTCOUNT_WIDTH + 1;
  localparam logic [CW-1:0] PAGE = CW'(BOUNDARY_WORDS);

  typedef enum logic [1:0] {IDLE, RD_SPLIT, WR_BURST} state_t;

  state_t                        state, state_nxt;
  logic [ADDR_WIDTH-1:0]         cur_addr, cur_addr_nxt;
  logic [CW-1:0]                 remaining, remaining_nxt;
  logic [CW-1:0]                 beat_cnt, beat_cnt_nxt;
  logic [ADDR_WIDTH-1:0]         piece_addr, piece_addr_nxt;
  logic [BURSTCOUNT_WIDTH-1:0]   piece_len, piece_len_nxt;
  logic                          split_inc;

  logic [CW-1:0] req_len, room_src, piece_src, rem_piece;

  // Data paths are untouched.
  assign snk_writedata     = src_writedata;
  assign snk_byteenable    = src_byteenable;
  assign src_readdata      = snk_readdata;
  assign src_readdatavalid = snk_readdatavalid;

  // First-piece length for a new command, and the next piece length once page-aligned.
  always_comb begin
    req_len   = CW'(src_burstcount);
    room_src  = PAGE - CW'(src_address[OW-1:0]);
    piece_src = (req_len < room_src) ? req_len : room_src;
    rem_piece = (remaining > PAGE) ? PAGE : remaining;
  end

  // Next-state and command rewrite.
  always_comb begin
    state_nxt       = state;
    cur_addr_nxt    = cur_addr;
    remaining_nxt   = remaining;
    beat_cnt_nxt    = beat_cnt;
    piece_addr_nxt  = piece_addr;
    piece_len_nxt   = piece_len;
    split_inc       = 1'b0;
    snk_read        = 1'b0;
    snk_write       = 1'b0;
    snk_address     = src_address;
    snk_burstcount  = src_burstcount;
    src_waitrequest = snk_waitrequest;
    case (state)
      IDLE: begin
        if (src_read) begin
          snk_read       = 1'b1;
          snk_burstcount = piece_src[BURSTCOUNT_WIDTH-1:0];
          if (piece_src != req_len) begin
            // Upstream is held until the last piece is accepted.
            src_waitrequest = 1'b1;
            if (!snk_waitrequest) begin
              cur_addr_nxt  = src_address + ADDR_WIDTH'(piece_src);
              remaining_nxt = req_len - piece_src;
              state_nxt     = RD_SPLIT;
            end
          end
        end else if (src_write) begin
          snk_write      = 1'b1;
          snk_burstcount = piece_src[BURSTCOUNT_WIDTH-1:0];
          if (!snk_waitrequest && req_len != CW'(1)) begin
            remaining_nxt  = req_len - CW'(1);
            beat_cnt_nxt   = piece_src - CW'(1);
            cur_addr_nxt   = src_address + ADDR_WIDTH'(piece_src);
            piece_addr_nxt = src_address;
            piece_len_nxt  = piece_src[BURSTCOUNT_WIDTH-1:0];
            state_nxt      = WR_BURST;
          end
        end
      end
      RD_SPLIT: begin
        snk_read       = 1'b1;
        snk_address    = cur_addr;
        snk_burstcount = rem_piece[BURSTCOUNT_WIDTH-1:0];
        if (remaining > PAGE) src_waitrequest = 1'b1;
        if (!snk_waitrequest) begin
          split_inc     = 1'b1;
          cur_addr_nxt  = cur_addr + ADDR_WIDTH'(rem_piece);
          remaining_nxt = remaining - rem_piece;
          if (remaining <= PAGE) state_nxt = IDLE;
        end
      end
      WR_BURST: begin
        // Reads issued mid-burst are a protocol violation and are dropped.
        snk_write = src_write;
        if (beat_cnt == '0) begin
          snk_address    = cur_addr;
          snk_burstcount = rem_piece[BURSTCOUNT_WIDTH-1:0];
        end else begin
          snk_address    = piece_addr;
          snk_burstcount = piece_len;
        end
        if (src_write && !snk_waitrequest) begin
          remaining_nxt = remaining - CW'(1);
          if (beat_cnt == '0) begin
            split_inc      = 1'b1;
            beat_cnt_nxt   = rem_piece - CW'(1);
            cur_addr_nxt   = cur_addr + ADDR_WIDTH'(rem_piece);
            piece_addr_nxt = cur_addr;
            piece_len_nxt  = rem_piece[BURSTCOUNT_WIDTH-1:0];
          end else begin
            beat_cnt_nxt = beat_cnt - CW'(1);
          end
          if (remaining == CW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Quiet the sink and stall upstream for as long as reset is held.
    if (!reset_n) begin
      snk_read        = 1'b0;
      snk_write       = 1'b0;
      src_waitrequest = 1'b1;
    end
  end

  // State and burst-tracking registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      beat_cnt   <= '0;
      piece_addr <= '0;
      piece_len  <= '0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= cur_addr_nxt;
      remaining  <= remaining_nxt;
      beat_cnt   <= beat_cnt_nxt;
      piece_addr <= piece_addr_nxt;
      piece_len  <= piece_len_nxt;
    end
  end

`ifdef HOST_PAGE_SPLIT_STATS_EN
  assign split_busy = (state != IDLE);

  // Saturating count of sub-bursts beyond the first of each command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) split_count <= '0;
    else if (split_inc && split_count != 32'hFFFF_FFFF) split_count <= split_count + 32'd1;
  end
`else
  logic unused_split_inc;
  assign unused_split_inc = split_inc;
`endif

endmodule
